load_store_unit: RTL
====================

# load_store_unit

- Sits in the MEM stage directly upstream of the word-addressed data memory.
- Converts byte-addressed pipeline load/store requests (byte, halfword, word; signed/unsigned) into the memory's word-only read/write port.
- Sub-word stores become a two-cycle read-modify-write; loaded data is extracted and sign/zero-extended.
- Stalls the pipeline while an access is in flight and flags misaligned accesses.

## Interface
- WORD_AW, 5, word-index width; memory depth is 2^WORD_AW words
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM-stage access request
- req_load  in  1  1 = load, 0 = store
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_ready  out  1  request accepted when req_valid & req_ready; low = pipeline stall
- resp_valid  out  1  one-cycle pulse, load result valid
- resp_data  out  32  extended load result
- misalign  out  1  one-cycle pulse, rejected access
- mem_raddr  out  32  word index, zero-extended
- mem_read  out  1  memory read strobe
- mem_waddr  out  32  word index, zero-extended
- mem_write  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory registered read data, valid the cycle after mem_read

## Operation
- Byte order is little-endian: byte k = bits [8k+7:8k]. Word index = req_addr[WORD_AW+1:2]; upper bits are ignored, so addresses wrap.
- Request fields are latched on accept. Outputs must not depend on req_* after the accept cycle.
- FSM states: IDLE, LOAD_WAIT, RMW.
- IDLE: req_ready = 1.
  - Word store: mem_write = 1 with waddr/wdata in the accept cycle. Stay in IDLE.
  - Load: mem_read = 1 in the accept cycle. Go to LOAD_WAIT.
  - Sub-word store: mem_read = 1 in the accept cycle. Go to RMW.
  - Misaligned or size 11: no memory strobe. Stay in IDLE.
- LOAD_WAIT: req_ready = 0.
  - Extract the addressed lane from mem_rdata and extend it.
  - Register the result into resp_data and pulse resp_valid at the next edge.
  - Go to IDLE.
- RMW: req_ready = 0.
  - Merge the store lane into mem_rdata.
  - Drive mem_write = 1 with the merged word at the same word index.
  - Go to IDLE.
- Misaligned accesses: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 11. The access is consumed and misalign pulses the cycle after accept.
- resp_data holds its last value between pulses.

## Timing
- Reset values:
  - State = IDLE.
  - resp_valid = 0, misalign = 0, resp_data = 0.
  - req_ready = 0 while rst is high.
  - mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata all 0 while rst is high.
- Latencies:
  - Load: resp_valid two cycles after accept. Throughput is one load per 2 cycles.
  - Word store: write strobe in the accept cycle. Throughput is 1 per cycle.
  - Sub-word store: write strobe one cycle after accept. Throughput is one per 2 cycles.
- A request may be accepted in the cycle the FSM returns to IDLE, i.e. the cycle resp_valid pulses.
- Reset mid-operation: rst in LOAD_WAIT or RMW aborts the access. There is no mem_write and no resp_valid, and the FSM returns to IDLE.
- mem_* strobes are combinational from state and request. They are sampled by the memory at the same edge.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misalignment is detected as above. The faulting access is dropped and misalign pulses.
- Not defined:
  - Misaligned addresses are silently aligned down: half clears addr[0], word clears addr[1:0].
  - Size 11 is treated as word.
  - misalign is tied 0.

## Structure
- Package lsu_pkg holds:
  - the size encoding typedef (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state typedef.
- One combinational sub-module, lsu_lane_align, is natural:
  - load lane extraction plus sign/zero extension;
  - store lane merge into a 32-bit word.
- The FSM and registers stay in load_store_unit.

## Test plan
- SW addr 0x8, data 0xDEADBEEF -> accept cycle: mem_write = 1, mem_waddr = 2, mem_wdata = 0xDEADBEEF; req_ready stays 1.
- Word 2 = 0x11228344:
  - LB addr 0x9 -> resp_data = 0xFFFFFF83, resp_valid exactly 2 cycles after accept.
  - LBU same address -> 0x00000083.
- Word 1 = 0x12345678, SH addr 0x6 data 0x0000CAFE:
  - cycle 0: mem_read with raddr 1;
  - cycle 1: req_ready = 0, mem_write with wdata 0xCAFE5678.
- LW addr 0x3:
  - with macro -> misalign pulse in cycle 1, no mem strobes;
  - without macro -> reads word 0 normally.
- rst asserted during the RMW cycle -> no mem_write; next cycle state IDLE, resp_valid = 0, req_ready = 0 until rst drops.
- SW 0x0 then LH 0x2 back-to-back -> both accepted on consecutive cycles; LH returns the upper half of the just-written word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM state
// type with its legacy-compatible constants, and small decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE      = 2'd0;
  localparam lsu_state_t ST_LOAD_WAIT = 2'd1;
  localparam lsu_state_t ST_RMW       = 2'd2;

  // True when the byte offset is illegal for the size (or the size is reserved).
  function automatic logic is_misaligned(lsu_size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Byte offset forced down to the natural alignment of the size.
  function automatic logic [1:0] align_off(lsu_size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: align_off = off;
      SZ_HALF: align_off = {off[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath: extracts and extends the addressed lane of a loaded
// word, and merges a right-justified store lane into a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  sh;
  logic [31:0] shifted;

  assign sh      = {off_i, 3'b000};
  assign shifted = rdata_i >> sh;

  // Load lane extraction with sign or zero extension.
  always_comb begin
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

  // Store lane merge into the previously read word.
  always_comb begin
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: merged_o = (rdata_i & ~(32'h0000_00FF << sh))
                        | ((wdata_i & 32'h0000_00FF) << sh);
      SZ_HALF: merged_o = (rdata_i & ~(32'h0000_FFFF << sh))
                        | ((wdata_i & 32'h0000_FFFF) << sh);
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-only data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned/reserved
// accesses); when undefined, addresses are aligned down and size 11 acts as word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WORD_AW = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        misalign,
  output logic [31:0] mem_raddr,
  output logic        mem_read,
  output logic [31:0] mem_waddr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t         state_q, state_d;
  lsu_size_e          req_sz, eff_size;
  logic [1:0]         eff_off;
  logic               bad;
  logic [WORD_AW-1:0] req_widx;

  logic [WORD_AW-1:0] widx_q;
  logic [1:0]         off_q;
  lsu_size_e          size_q;
  logic               uns_q;
  logic [31:0]        wdata_q;
  logic [31:0]        resp_data_q;
  logic               resp_valid_q;
  logic [31:0]        load_data, merged;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:WORD_AW+2];

  assign req_sz   = lsu_size_e'(req_size);
  assign req_widx = req_addr[WORD_AW+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign eff_size = req_sz;
  assign eff_off  = req_addr[1:0];
  assign bad      = is_misaligned(req_sz, req_addr[1:0]);
  assign misalign = misalign_q;

  // Misalign pulse the cycle after a rejected access is consumed.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= req_valid & req_ready & bad;
  end
`else
  assign eff_size = (req_sz == SZ_RSVD) ? SZ_WORD : req_sz;
  assign eff_off  = align_off(eff_size, req_addr[1:0]);
  assign bad      = 1'b0;
  assign misalign = 1'b0;
`endif

  lsu_lane_align u_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .off_i       (off_q),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  // Next state and memory strobes; the second RMW/load cycle uses only latched fields.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid && !bad) begin
            if (req_load) begin
              mem_read  = 1'b1;
              mem_raddr = 32'(req_widx);
              state_d   = ST_LOAD_WAIT;
            end else if (eff_size == SZ_WORD) begin
              mem_write = 1'b1;
              mem_waddr = 32'(req_widx);
              mem_wdata = req_wdata;
            end else begin
              mem_read  = 1'b1;
              mem_raddr = 32'(req_widx);
              state_d   = ST_RMW;
            end
          end
        end
        ST_LOAD_WAIT: state_d = ST_IDLE;
        ST_RMW: begin
          mem_write = 1'b1;
          mem_waddr = 32'(widx_q);
          mem_wdata = merged;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, latched request fields and registered load response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      widx_q       <= '0;
      off_q        <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_q == ST_LOAD_WAIT);
      if (state_q == ST_LOAD_WAIT) resp_data_q <= load_data;
      if (req_valid && req_ready) begin
        widx_q  <= req_widx;
        off_q   <= eff_off;
        size_q  <= eff_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule
